// File: rtl/clock_display_scan.sv
// clock_display_scan: snapshots 12h time per frame, double-dabbles to BCD, scans a 6-digit common-anode display
module clock_display_scan #(
  parameter int SCAN_DIV   = 1000,
  parameter bit BLANK_LEAD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       busy,
  output logic       err
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH = 7'h3F;
  if (SCAN_DIV < 16) begin : g_chk
    $error("SCAN_DIV must be >= 16");
  end
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0] idx_q, idx_d, cnt_q, cnt_d;
  logic req_q, req_d, pm_s_q, pm_s_d, err_s_q, err_s_d, pm_q, pm_d, err_q, err_d;
  logic [2:0][7:0] snap_q, snap_d;
  logic [2:0][19:0] sr_q, sr_d;
  logic [5:0][6:0] dig_q, dig_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  logic [5:0] an_q, an_d;
  logic tc, wrap;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = DASH;
    endcase
  endfunction
  function automatic logic [19:0] dd(input logic [19:0] x);
    logic [19:0] y;
    y = x;
    for (int i = 0; i < 3; i++)
      if (y[8+4*i +: 4] >= 4'd5) y[8+4*i +: 4] = y[8+4*i +: 4] + 4'd3;
    return y << 1;
  endfunction
  always_comb begin
    tc = pre_q == PW'(SCAN_DIV - 1);
    wrap = tc && idx_q == 3'd5;
    pre_d = tc ? '0 : pre_q + PW'(1);
    idx_d = tc ? (wrap ? 3'd0 : idx_q + 3'd1) : idx_q;
    req_d = wrap | (req_q & (state_q != IDLE));
    state_d = state_q;
    snap_d = snap_q;
    pm_s_d = pm_s_q;
    err_s_d = err_s_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    dig_d = dig_q;
    pm_d = pm_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_q) begin
        snap_d = {hh, mm, ss};
        pm_s_d = pm;
        err_s_d = hh == 8'd0 || hh > 8'd12 || mm > 8'd59 || ss > 8'd59;
        state_d = LOAD;
      end
      LOAD: begin
        for (int f = 0; f < 3; f++) sr_d[f] = {12'd0, snap_q[f]};
        cnt_d = 3'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        for (int f = 0; f < 3; f++) sr_d[f] = dd(sr_q[f]);
        cnt_d = cnt_q + 3'd1;
        state_d = cnt_q == 3'd7 ? DONE : SHIFT;
      end
      DONE: begin
        for (int f = 0; f < 3; f++) begin
          dig_d[2*f] = err_s_q ? DASH : dec(sr_q[f][11:8]);
          dig_d[2*f+1] = err_s_q ? DASH : dec(sr_q[f][15:12]);
        end
        if (BLANK_LEAD && !err_s_q && sr_q[2][15:12] == 4'd0) dig_d[5] = BLANK;
        pm_d = pm_s_q;
        err_d = err_s_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    an_d = ~(6'd1 << idx_d);
    seg_d = dig_d[idx_d];
    dp_d = (idx_d == 3'd2 || idx_d == 3'd4) ? 1'b0 : (idx_d == 3'd0) ? ~(pm_d & ~err_d) : 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q <= '0;
      idx_q <= 3'd0;
      cnt_q <= 3'd0;
      req_q <= 1'b1;
      snap_q <= '0;
      pm_s_q <= 1'b0;
      err_s_q <= 1'b0;
      sr_q <= '0;
      dig_q <= {6{BLANK}};
      pm_q <= 1'b0;
      err_q <= 1'b0;
      seg_q <= BLANK;
      dp_q <= 1'b1;
      an_q <= 6'h3F;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      snap_q <= snap_d;
      pm_s_q <= pm_s_d;
      err_s_q <= err_s_d;
      sr_q <= sr_d;
      dig_q <= dig_d;
      pm_q <= pm_d;
      err_q <= err_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_q <= an_d;
    end
  end
  assign seg = seg_q;
  assign dp = dp_q;
  assign an = an_q;
  assign busy = state_q == LOAD || state_q == SHIFT;
  assign err = err_q;
endmodule
